die_temp_monitor: RTL and testbench

- Sits directly downstream of the XADC die-temperature reader and consumes its 16-bit register output, which holds the 12-bit raw code in bits [11:0].
- Samples the code at a fixed rate and block-averages 2^AVG_LOG2 samples.
- Runs an over-temperature alarm with hysteresis and counts alarm events for the housekeeping/telemetry logic.

---
 rtl/die_temp_monitor.sv | 167 ++++++++++++++++
 tb/tb_die_temp_monitor.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/die_temp_monitor.sv
// die_temp_monitor: samples the XADC die-temperature code at a fixed rate,
// block-averages 2^AVG_LOG2 valid samples, and drives a hysteretic
// over-temperature alarm with a saturating event counter.
// Optional peak hold (running max/min of averages) enabled by TEMP_PEAK_HOLD_EN.
module die_temp_monitor #(
  parameter int unsigned SAMPLE_DIV = 21000,
  parameter int unsigned AVG_LOG2   = 4,
  parameter logic [11:0] HI_THRESH  = 12'd2911,
  parameter logic [11:0] LO_THRESH  = 12'd2830
) (
  input  logic        clk210_p,
  input  logic        reset_p,
  input  logic [15:0] fpga_die_temp_p,
  input  logic        peak_clr_p,
  output logic [11:0] temp_avg_p,
  output logic        avg_valid_p,
  output logic        over_temp_p,
  output logic [7:0]  over_temp_events_p,
  output logic [11:0] temp_max_p,
  output logic [11:0] temp_min_p
);

  localparam int unsigned TICK_W = $clog2(SAMPLE_DIV);
  localparam int unsigned ACC_W  = 12 + AVG_LOG2;
  localparam int unsigned SCNT_W = AVG_LOG2 + 1;

  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(SAMPLE_DIV - 1);
  localparam logic [SCNT_W-1:0] SCNT_LAST = SCNT_W'((1 << AVG_LOG2) - 1);

  typedef enum logic [1:0] {
    ST_WARMUP = 2'd0,
    ST_NORMAL = 2'd1,
    ST_HOT    = 2'd2
  } state_t;

  logic [TICK_W-1:0] tick_cnt;
  logic [ACC_W-1:0]  acc;
  logic [SCNT_W-1:0] samp_cnt;
  state_t            state_q;
  state_t            state_d;

  logic              tick_c;
  logic [11:0]       sample_c;
  logic              sample_ok_c;
  logic              last_c;
  logic              avg_update_c;
  logic [ACC_W-1:0]  sum_c;
  logic [11:0]       avg_c;
  logic              enter_hot_c;
  logic              unused_c;

  // Sample strobe and averaging datapath; a zero code means no conversion yet.
  assign tick_c       = (tick_cnt == TICK_LAST);
  assign sample_c     = fpga_die_temp_p[11:0];
  assign sample_ok_c  = tick_c && (sample_c != 12'd0);
  assign last_c       = (samp_cnt == SCNT_LAST);
  assign avg_update_c = sample_ok_c && last_c;
  assign sum_c        = acc + ACC_W'(sample_c);
  assign avg_c        = 12'(sum_c >> AVG_LOG2);

  // Free-running sample-rate divider, wraps at SAMPLE_DIV-1.
  always_ff @(posedge clk210_p or posedge reset_p) begin
    if (reset_p) begin
      tick_cnt <= '0;
    end else if (tick_c) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + TICK_W'(1);
    end
  end

  // Accumulate valid samples; restart the block when the average is published.
  always_ff @(posedge clk210_p or posedge reset_p) begin
    if (reset_p) begin
      acc      <= '0;
      samp_cnt <= '0;
    end else if (sample_ok_c) begin
      if (last_c) begin
        acc      <= '0;
        samp_cnt <= '0;
      end else begin
        acc      <= sum_c;
        samp_cnt <= samp_cnt + SCNT_W'(1);
      end
    end
  end

  // Alarm state register.
  always_ff @(posedge clk210_p or posedge reset_p) begin
    if (reset_p) begin
      state_q <= ST_WARMUP;
    end else begin
      state_q <= state_d;
    end
  end

  // Alarm next-state: evaluated only on a fresh average, with hysteresis in HOT.
  always_comb begin
    state_d     = state_q;
    enter_hot_c = 1'b0;
    if (avg_update_c) begin
      case (state_q)
        ST_WARMUP, ST_NORMAL: begin
          if (avg_c >= HI_THRESH) begin
            state_d = ST_HOT;
          end else begin
            state_d = ST_NORMAL;
          end
        end
        ST_HOT: begin
          if (avg_c < LO_THRESH) begin
            state_d = ST_NORMAL;
          end
        end
        default: state_d = ST_WARMUP;
      endcase
      enter_hot_c = (state_q != ST_HOT) && (state_d == ST_HOT);
    end
  end

  // Registered outputs: average, valid pulse, alarm level and event count move together.
  always_ff @(posedge clk210_p or posedge reset_p) begin
    if (reset_p) begin
      temp_avg_p         <= 12'd0;
      avg_valid_p        <= 1'b0;
      over_temp_p        <= 1'b0;
      over_temp_events_p <= 8'd0;
    end else begin
      avg_valid_p <= avg_update_c;
      if (avg_update_c) begin
        temp_avg_p  <= avg_c;
        over_temp_p <= (state_d == ST_HOT);
      end
      if (enter_hot_c && (over_temp_events_p != 8'hFF)) begin
        over_temp_events_p <= over_temp_events_p + 8'd1;
      end
    end
  end

`ifdef TEMP_PEAK_HOLD_EN
  // Running max/min of published averages; a clear wins over a same-cycle update.
  always_ff @(posedge clk210_p or posedge reset_p) begin
    if (reset_p) begin
      temp_max_p <= 12'h000;
      temp_min_p <= 12'hFFF;
    end else if (peak_clr_p) begin
      temp_max_p <= 12'h000;
      temp_min_p <= 12'hFFF;
    end else if (avg_valid_p) begin
      if (temp_avg_p > temp_max_p) begin
        temp_max_p <= temp_avg_p;
      end
      if (temp_avg_p < temp_min_p) begin
        temp_min_p <= temp_avg_p;
      end
    end
  end

  assign unused_c = ^fpga_die_temp_p[15:12];
`else
  // Peak hold absent: outputs sit at their cleared values.
  assign temp_max_p = 12'h000;
  assign temp_min_p = 12'hFFF;
  assign unused_c   = ^{fpga_die_temp_p[15:12], peak_clr_p};
`endif

endmodule

// File: tb/tb_die_temp_monitor.sv
// Testbench for die_temp_monitor (SAMPLE_DIV=4, AVG_LOG2=2).
// Reference model keeps a queue of valid samples and applies the alarm rules directly.
module tb_die_temp_monitor;

  localparam int SD = 4;
  localparam int AL = 2;
  localparam int N  = 1 << AL;
  localparam int HI = 2911;
  localparam int LO = 2830;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] din = 16'h0000;
  logic        clr = 1'b0;
  logic [11:0] temp_avg_p;
  logic        avg_valid_p;
  logic        over_temp_p;
  logic [7:0]  over_temp_events_p;
  logic [11:0] temp_max_p;
  logic [11:0] temp_min_p;

  int n_cmp  = 0;
  int n_fail = 0;

  die_temp_monitor #(
    .SAMPLE_DIV(SD),
    .AVG_LOG2  (AL),
    .HI_THRESH (12'd2911),
    .LO_THRESH (12'd2830)
  ) dut (
    .clk210_p          (clk),
    .reset_p           (rst),
    .fpga_die_temp_p   (din),
    .peak_clr_p        (clr),
    .temp_avg_p        (temp_avg_p),
    .avg_valid_p       (avg_valid_p),
    .over_temp_p       (over_temp_p),
    .over_temp_events_p(over_temp_events_p),
    .temp_max_p        (temp_max_p),
    .temp_min_p        (temp_min_p)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  int          m_cyc   = 0;
  int          m_q[$];
  int          m_hot   = 0;
  logic [11:0] exp_avg = 12'd0;
  logic        exp_valid = 1'b0;
  logic        exp_over  = 1'b0;
  int          exp_ev  = 0;
  logic [11:0] exp_max = 12'h000;
  logic [11:0] exp_min = 12'hFFF;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_cyc = 0; m_q.delete(); m_hot = 0;
      exp_avg = 12'd0; exp_valid = 1'b0; exp_over = 1'b0; exp_ev = 0;
      exp_max = 12'h000; exp_min = 12'hFFF;
    end else begin
`ifdef TEMP_PEAK_HOLD_EN
      if (clr) begin
        exp_max = 12'h000; exp_min = 12'hFFF;
      end else if (exp_valid) begin
        if (exp_avg > exp_max) exp_max = exp_avg;
        if (exp_avg < exp_min) exp_min = exp_avg;
      end
`endif
      exp_valid = 1'b0;
      if ((m_cyc % SD) == SD - 1 && din[11:0] != 12'd0) begin
        m_q.push_back(int'(din[11:0]));
        if (m_q.size() == N) begin
          int s;
          int a;
          s = 0;
          foreach (m_q[k]) s += m_q[k];
          a = s / N;
          exp_avg = 12'(a);
          exp_valid = 1'b1;
          if (m_hot != 0) begin
            if (a < LO) m_hot = 0;
          end else if (a >= HI) begin
            m_hot = 1;
            if (exp_ev < 255) exp_ev++;
          end
          exp_over = (m_hot != 0);
          m_q.delete();
        end
      end
      m_cyc++;
    end
  end

  // ---------------- stimulus helpers (no checking) ----------------
  task automatic do_reset();
    rst = 1'b1; clr = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic feed(input logic [15:0] v, input int ticks);
    din = v;
    repeat (ticks * SD) begin
      @(posedge clk); #1;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    din = 16'h0B00;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    n_cmp++; if (temp_avg_p !== 12'd0) begin n_fail++; $display("FAIL reset_avg got %h want 000", temp_avg_p); end
    n_cmp++; if (avg_valid_p !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", avg_valid_p); end
    n_cmp++; if (over_temp_p !== 1'b0) begin n_fail++; $display("FAIL reset_over got %b want 0", over_temp_p); end
    n_cmp++; if (over_temp_events_p !== 8'd0) begin n_fail++; $display("FAIL reset_events got %0d want 0", over_temp_events_p); end
    n_cmp++; if (temp_max_p !== 12'h000) begin n_fail++; $display("FAIL reset_max got %h want 000", temp_max_p); end
    n_cmp++; if (temp_min_p !== 12'hFFF) begin n_fail++; $display("FAIL reset_min got %h want fff", temp_min_p); end
    do_reset();
  endtask

  task automatic test_warmup();
    int first;
    do_reset();
    din = 16'h0B00;
    first = -1;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (avg_valid_p === 1'b1) begin first = i; break; end
    end
    n_cmp++; if (first != 16) begin n_fail++; $display("FAIL warmup_latency got %0d want 16", first); end
    n_cmp++; if (temp_avg_p !== 12'hB00) begin n_fail++; $display("FAIL warmup_avg got %h want b00", temp_avg_p); end
    n_cmp++; if (over_temp_p !== 1'b0) begin n_fail++; $display("FAIL warmup_over got %b want 0", over_temp_p); end
    @(posedge clk); #1;
    n_cmp++; if (avg_valid_p !== 1'b0) begin n_fail++; $display("FAIL warmup_pulse_width got %b want 0", avg_valid_p); end
  endtask

  task automatic test_zero_skip();
    do_reset();
    feed(16'h0000, 3);
    feed(16'h0A00, 3);
    n_cmp++; if (avg_valid_p !== 1'b0 || temp_avg_p !== 12'd0) begin
      n_fail++; $display("FAIL zero_skip_early got valid=%b avg=%h want 0/000", avg_valid_p, temp_avg_p);
    end
    feed(16'h0A00, 1);
    n_cmp++; if (avg_valid_p !== 1'b1 || temp_avg_p !== 12'hA00) begin
      n_fail++; $display("FAIL zero_skip_avg got valid=%b avg=%h want 1/a00", avg_valid_p, temp_avg_p);
    end
  endtask

  task automatic test_alarm();
    feed(16'd2910, 1); feed(16'd2911, 1); feed(16'd2912, 1); feed(16'd2913, 1);
    n_cmp++; if ({avg_valid_p, temp_avg_p, over_temp_p, over_temp_events_p} !== {1'b1, 12'd2911, 1'b1, 8'd1}) begin
      n_fail++; $display("FAIL alarm_set got v=%b avg=%0d ot=%b ev=%0d want 1/2911/1/1",
                         avg_valid_p, temp_avg_p, over_temp_p, over_temp_events_p);
    end
    feed(16'd2850, 4);
    n_cmp++; if (over_temp_p !== 1'b1 || temp_avg_p !== 12'd2850) begin
      n_fail++; $display("FAIL alarm_hyst got ot=%b avg=%0d want 1/2850", over_temp_p, temp_avg_p);
    end
    feed(16'd2829, 4);
    n_cmp++; if (over_temp_p !== 1'b0 || temp_avg_p !== 12'd2829) begin
      n_fail++; $display("FAIL alarm_clear got ot=%b avg=%0d want 0/2829", over_temp_p, temp_avg_p);
    end
    feed(16'd2911, 4);
    n_cmp++; if (over_temp_p !== 1'b1 || over_temp_events_p !== 8'd2) begin
      n_fail++; $display("FAIL alarm_reset got ot=%b ev=%0d want 1/2", over_temp_p, over_temp_events_p);
    end
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 300; i++) begin
      feed(16'd2000, 4);
      feed(16'd3000, 4);
    end
    n_cmp++; if (over_temp_events_p !== 8'd255 || over_temp_p !== 1'b1) begin
      n_fail++; $display("FAIL events_saturate got ev=%0d ot=%b want 255/1", over_temp_events_p, over_temp_p);
    end
    n_cmp++; if (over_temp_events_p !== 8'(exp_ev)) begin
      n_fail++; $display("FAIL events_model got %0d want %0d", over_temp_events_p, exp_ev);
    end
  endtask

  task automatic test_reset_mid();
    feed(16'd3000, 2);
    rst = 1'b1;
    #1;
    n_cmp++; if ({temp_avg_p, avg_valid_p, over_temp_p, over_temp_events_p} !== {12'd0, 1'b0, 1'b0, 8'd0}) begin
      n_fail++; $display("FAIL reset_mid got avg=%h v=%b ot=%b ev=%0d want 000/0/0/0",
                         temp_avg_p, avg_valid_p, over_temp_p, over_temp_events_p);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    feed(16'h0C00, 3);
    n_cmp++; if (avg_valid_p !== 1'b0 || temp_avg_p !== 12'd0) begin
      n_fail++; $display("FAIL reset_mid_partial got v=%b avg=%h want 0/000", avg_valid_p, temp_avg_p);
    end
    feed(16'h0C00, 1);
    n_cmp++; if ({avg_valid_p, temp_avg_p, over_temp_p, over_temp_events_p} !== {1'b1, 12'hC00, 1'b1, 8'd1}) begin
      n_fail++; $display("FAIL reset_mid_fresh got v=%b avg=%h ot=%b ev=%0d want 1/c00/1/1",
                         avg_valid_p, temp_avg_p, over_temp_p, over_temp_events_p);
    end
  endtask

  task automatic test_peak_hold();
    do_reset();
`ifdef TEMP_PEAK_HOLD_EN
    feed(16'd2800, 4); feed(16'd2900, 4); feed(16'd2700, 4);
    din = 16'd2750;
    @(posedge clk); #1;
    n_cmp++; if (temp_max_p !== 12'd2900 || temp_min_p !== 12'd2700) begin
      n_fail++; $display("FAIL peak_track got max=%0d min=%0d want 2900/2700", temp_max_p, temp_min_p);
    end
    repeat (15) begin @(posedge clk); #1; end
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    n_cmp++; if (temp_max_p !== 12'h000 || temp_min_p !== 12'hFFF) begin
      n_fail++; $display("FAIL peak_clear got max=%h min=%h want 000/fff", temp_max_p, temp_min_p);
    end
    din = 16'd2760;
    repeat (15) begin @(posedge clk); #1; end
    din = 16'd2770;
    @(posedge clk); #1;
    n_cmp++; if (temp_max_p !== 12'd2760 || temp_min_p !== 12'd2760) begin
      n_fail++; $display("FAIL peak_reload got max=%0d min=%0d want 2760/2760", temp_max_p, temp_min_p);
    end
`else
    clr = 1'b1;
    feed(16'd2800, 4);
    feed(16'd2900, 1);
    clr = 1'b0;
    n_cmp++; if (temp_max_p !== 12'h000 || temp_min_p !== 12'hFFF) begin
      n_fail++; $display("FAIL peak_tied got max=%h min=%h want 000/fff", temp_max_p, temp_min_p);
    end
`endif
  endtask

  task automatic test_random();
    logic [45:0] act;
    logic [45:0] exp;
    int r;
    for (int i = 0; i < 3000; i++) begin
      r = int'($urandom_range(0, 7));
      case (r)
        0:       din = {4'($urandom), 12'h000};
        6:       din = 16'($urandom);
        7:       din = din;
        default: din = {4'($urandom), 12'($urandom_range(2700, 3100))};
      endcase
      clr = ($urandom_range(0, 49) == 0);
      if ($urandom_range(0, 599) == 0) begin
        rst = 1'b1;
        #1;
        n_cmp++; if (over_temp_events_p !== 8'd0 || temp_avg_p !== 12'd0) begin
          n_fail++; $display("FAIL random_async_reset got ev=%0d avg=%h want 0/000", over_temp_events_p, temp_avg_p);
        end
        @(posedge clk); #1;
        rst = 1'b0;
      end else begin
        @(posedge clk); #1;
      end
      act = {temp_avg_p, avg_valid_p, over_temp_p, over_temp_events_p, temp_max_p, temp_min_p};
      exp = {exp_avg, exp_valid, exp_over, 8'(exp_ev), exp_max, exp_min};
      n_cmp++;
      if (act !== exp) begin
        n_fail++;
        $display("FAIL random_cycle%0d got avg=%h v=%b ot=%b ev=%0d max=%h min=%h want avg=%h v=%b ot=%b ev=%0d max=%h min=%h",
                 i, temp_avg_p, avg_valid_p, over_temp_p, over_temp_events_p, temp_max_p, temp_min_p,
                 exp_avg, exp_valid, exp_over, exp_ev, exp_max, exp_min);
      end
    end
    clr = 1'b0;
  endtask

  initial begin
    test_reset();
    test_warmup();
    test_zero_skip();
    test_alarm();
    test_saturation();
    test_reset_mid();
    test_peak_hold();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
